// File: rtl/tinycpu_mem_resp_if.sv
// ---------------------------------------------------------------------------
// tinycpu_mem_resp_if
//   Bus bundle between the tinycpu core (plus bench loader) and the memory
//   responder.
//
//   CPU request side : req, we, addr, wdata        (master -> slave)
//   CPU response side: rdata, ack                  (slave -> master)
//   Console          : out_data, out_valid         (slave -> master)
//   Bench load port  : ld_en, ld_addr, ld_data     (master -> slave)
//   Status           : busy                        (slave -> master)
// ---------------------------------------------------------------------------
interface tinycpu_mem_resp_if;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;
    logic [7:0] out_data;
    logic       out_valid;
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    logic       busy;

    modport master (
        output req, we, addr, wdata, ld_en, ld_addr, ld_data,
        input  rdata, ack, out_data, out_valid, busy
    );

    modport slave (
        input  req, we, addr, wdata, ld_en, ld_addr, ld_data,
        output rdata, ack, out_data, out_valid, busy
    );
endinterface

// File: rtl/tinycpu_mem_resp.sv
// ---------------------------------------------------------------------------
// tinycpu_mem_resp
//   Target end of the tinycpu fetch/data bus. Holds a 256 x 8 RAM, serves
//   read/write requests over a req/ack handshake with WAIT_STATES extra
//   cycles, mirrors writes to OUT_ADDR onto a console output register, and
//   accepts bench-side preloads while idle.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-low reset
//     bus    - tinycpu_mem_resp_if.slave (req/we/addr/wdata in, rdata/ack out,
//              out_data/out_valid console, ld_en/ld_addr/ld_data load, busy)
//
//   Parameters:
//     WAIT_STATES - extra cycles between acceptance and ack (0..15)
//     OUT_ADDR    - address whose writes also drive out_data
// ---------------------------------------------------------------------------
module tinycpu_mem_resp #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [7:0]  OUT_ADDR    = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    tinycpu_mem_resp_if.slave  bus
);

    localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [3:0] r_cnt;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic [7:0] r_out_data;
    logic       r_out_valid;

    logic [7:0] r_mem [256];

    logic       w_load;
    logic       w_accept;
    logic       w_access;
    logic       w_out_hit;
    logic       w_mem_we;
    logic [7:0] w_mem_addr;
    logic [7:0] w_mem_wdata;

    // Next-state and strobe decode. Loads win over requests in IDLE and the
    // request simply stays pending; loads anywhere else are dropped so they
    // can never collide with a CPU access on the RAM write port.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ld_en) begin
                    w_load = 1'b1;
                end else if (bus.req) begin
                    w_accept     = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_state_next = ACK;
                end
            end
            ACK: begin
                // req is deliberately ignored here; a held req is re-accepted
                // only after the return to IDLE.
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_out_hit = r_we && (r_addr == OUT_ADDR);

    // Single RAM write port shared by the loader and committed CPU writes;
    // the FSM guarantees the two never fire in the same cycle.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata;
        if (w_load) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = bus.ld_addr;
            w_mem_wdata = bus.ld_data;
        end else if (w_access && r_we) begin
            w_mem_we = 1'b1;
        end
    end

    // RAM array: no reset, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_rdata     <= 8'h00;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_cnt   <= LP_WAIT;
                r_we    <= bus.we;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Registered read; rdata is left untouched outside a read access.
            if (w_access && !r_we) begin
                r_rdata <= r_mem[r_addr];
            end

            if (w_access && w_out_hit) begin
                r_out_data <= r_wdata;
            end

            // Raised on the access edge so it lines up with the ACK cycle.
            r_out_valid <= w_access && w_out_hit;
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.ack       = (r_state == ACK);
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: doc/tinycpu_mem_resp.md
Name: tinycpu_mem_resp

Overview:
- Memory responder for the tinycpu bus: the target end of the CPU's instruction/data fetch interface.
- Holds a 256 x 8 RAM, answers CPU read/write requests over a req/ack handshake with a programmable number of wait states, and exposes a memory-mapped console output register.
- Includes a bench-side load port for preloading programs while the bus is idle.
- Instantiated beside the CPU core in the simulation environment.

Parameters:
- WAIT_STATES, 0, extra cycles inserted between request acceptance and ack (0..15).
- OUT_ADDR, 8'hFF, address whose writes also drive the console output port.

Ports:
- clk  input  1  system clock, all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  1  CPU access request; held high until ack is seen
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  8  access address; sampled with req
- wdata  input  8  write data; sampled with req
- rdata  output  8  read data; valid while ack is high
- ack  output  1  one-cycle completion pulse
- out_data  output  8  last value written to OUT_ADDR
- out_valid  output  1  one-cycle pulse coincident with ack of an OUT_ADDR write
- ld_en  input  1  bench load strobe
- ld_addr  input  8  load address
- ld_data  input  8  load data
- busy  output  1  high in WAIT or ACK

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; ack, out_valid, busy, rdata, out_data all 0; wait counter 0.
  - RAM contents are not cleared.
  - Any access in flight is dropped; an uncommitted write is lost.
- States: IDLE, WAIT, ACK.
- IDLE:
  - If ld_en = 1 at the edge: RAM[ld_addr] <= ld_data; state stays IDLE. ld_en has priority over req, and req remains pending.
  - Else if req = 1: latch we, addr, wdata; counter <= WAIT_STATES; go to WAIT.
- WAIT:
  - If counter != 0: decrement.
  - If counter == 0, at the same edge:
    - Perform the access: read latches RAM[addr] into rdata; write stores wdata into RAM[addr].
    - If the write targets OUT_ADDR, also set out_data <= wdata and raise out_valid.
    - Go to ACK.
- ACK:
  - ack = 1 for exactly this cycle; rdata holds read data; out_valid high only for an OUT_ADDR write.
  - Next edge: return to IDLE unconditionally; req is ignored during ACK.
- Latency and ordering:
  - req sampled at edge N -> ack high in the cycle after edge N+1+WAIT_STATES.
  - Minimum spacing between accepted requests is WAIT_STATES+3 edges.
- Handshake rules:
  - The initiator must keep we/addr/wdata stable only until the accepting edge; later changes are ignored.
  - Dropping req during WAIT does not abort the access; ack still pulses.
- Readback and hold values:
  - Reads of OUT_ADDR return the RAM copy, not out_data.
  - rdata holds its last value outside ACK (it is not cleared).
  - out_data holds until the next OUT_ADDR write or reset.
- ld_en outside IDLE is ignored (no write), so loads never race CPU accesses.
- Address wrap: 8-bit address, no out-of-range case; 8'hFF and 8'h00 are ordinary locations apart from OUT_ADDR.
- busy = (state != IDLE).

Test Plan:
- Preload then read: ld_en writes 8'h3C to 8'h10; req read 8'h10 with WAIT_STATES=0 -> ack one cycle, two edges after acceptance, rdata = 8'h3C; busy high for 2 cycles.
- Wait states: WAIT_STATES=3, write 8'hA5 to 8'h20, then read 8'h20 -> each ack arrives 5 edges after acceptance, exactly one cycle wide; rdata = 8'hA5.
- Console: write 8'h41 to 8'hFF -> out_valid and ack pulse together, out_data = 8'h41 and held; read 8'hFF returns 8'h41 from RAM; a write to 8'hFE leaves out_valid 0 and out_data unchanged.
- Priority and ignore: ld_en and req both high in IDLE -> load commits, request is accepted next edge. ld_en during WAIT -> target location unchanged. req held high through ACK -> a second access starts only after return to IDLE.
- Reset mid-operation: WAIT_STATES=4, write 8'h77 to 8'h30, pull reset low in the second WAIT cycle -> ack never pulses, all outputs 0, RAM[8'h30] keeps its old value. Preloaded locations survive reset.
- Program run: preload a tinycpu program ending in a jump-to-self, run the CPU against this block -> the bench's forever-loop detector halts the run. The expected console bytes appear on out_data, one out_valid pulse each.
